// File: rtl/tff_bank_sequencer.sv
// Sequences an external bank of W toggle flip-flops as a modulo-MOD up/down counter
// with parallel load and preset, verifying the bank readback after every command.
module tff_bank_sequencer #(
    parameter int W   = 4,
    parameter int MOD = 10
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         cmd_valid,
    output logic         cmd_ready,
    input  logic [1:0]   cmd_op,
    input  logic [W-1:0] cmd_data,
    input  logic [W-1:0] q_vec,
    output logic [W-1:0] t_vec,
    output logic [W-1:0] set_vec,
    output logic         busy,
    output logic         done,
    output logic         err
);

    typedef enum logic [1:0] {
        OP_LOAD   = 2'b00,
        OP_UP     = 2'b01,
        OP_DOWN   = 2'b10,
        OP_PRESET = 2'b11
    } op_t;

    typedef enum logic [2:0] {
        S_IDLE,
        S_LOAD,
        S_COUNT,
        S_PRESET,
        S_VERIFY
    } state_t;

    localparam logic [W-1:0] MOD_M1  = W'(MOD - 1);
    localparam logic [W:0]   MOD_EXT = (W + 1)'(MOD);

    state_t       r_state;
    op_t          r_op;
    logic [W-1:0] r_remaining;
    logic [W-1:0] r_expected;
    logic         r_err;
    logic         r_force_err;

    logic         w_up;
    logic         w_load_in_range;

    // Toggle mask that moves value v one step up or down, wrapping modulo MOD.
    function automatic logic [W-1:0] step_mask(input logic [W-1:0] v, input logic up);
        logic [W-1:0] m;
        m = '0;
        if (up && (v >= MOD_M1)) begin
            m = v;
        end else if (!up && (v == '0)) begin
            m = MOD_M1;
        end else begin
            m[0] = 1'b1;
            for (int i = 1; i < W; i++) begin
                m[i] = m[i-1] & (up ? v[i-1] : ~v[i-1]);
            end
        end
        return m;
    endfunction

    assign w_up            = (r_op == OP_UP);
    assign w_load_in_range = ({1'b0, cmd_data} < MOD_EXT);

    assign cmd_ready = (r_state == S_IDLE);
    assign busy      = (r_state != S_IDLE);
    assign done      = (r_state == S_VERIFY);
    assign err       = r_err;

    // NOTE: every output gets a default before the case so no latch is inferred.
    always_comb begin
        t_vec   = '0;
        set_vec = '0;
        case (r_state)
            S_LOAD:   t_vec   = q_vec ^ r_expected;
            S_COUNT:  t_vec   = step_mask(q_vec, w_up);
            S_PRESET: set_vec = '1;
            default: ;
        endcase
    end

    // NOTE: state registers use non-blocking assignments so every register samples
    // pre-edge values, matching real flip-flop behaviour.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state     <= S_IDLE;
            r_op        <= OP_LOAD;
            r_remaining <= '0;
            r_expected  <= '0;
            r_err       <= 1'b0;
            r_force_err <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (cmd_valid) begin
                        r_op        <= op_t'(cmd_op);
                        r_force_err <= 1'b0;
                        case (op_t'(cmd_op))
                            OP_LOAD: begin
                                if (w_load_in_range) begin
                                    r_expected <= cmd_data;
                                    r_err      <= 1'b0;
                                    r_state    <= S_LOAD;
                                end else begin
                                    // Out-of-range load: err keeps its value until VERIFY exit.
                                    r_expected  <= q_vec;
                                    r_force_err <= 1'b1;
                                    r_state     <= S_VERIFY;
                                end
                            end
                            OP_UP, OP_DOWN: begin
                                r_remaining <= cmd_data;
                                r_expected  <= q_vec;
                                r_err       <= 1'b0;
                                r_state     <= (cmd_data == '0) ? S_VERIFY : S_COUNT;
                            end
                            default: begin
                                r_expected <= '1;
                                r_err      <= 1'b0;
                                r_state    <= S_PRESET;
                            end
                        endcase
                    end
                end
                S_LOAD, S_PRESET: begin
                    r_state <= S_VERIFY;
                end
                S_COUNT: begin
                    r_expected  <= r_expected ^ step_mask(r_expected, w_up);
                    r_remaining <= r_remaining - 1'b1;
                    if (r_remaining == W'(1)) begin
                        r_state <= S_VERIFY;
                    end
                end
                S_VERIFY: begin
                    if ((q_vec != r_expected) || r_force_err) begin
                        r_err <= 1'b1;
                    end
                    r_force_err <= 1'b0;
                    r_state     <= S_IDLE;
                end
                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_tff_bank_sequencer.sv
// Bench for tff_bank_sequencer: models the flip-flop bank, predicts every output per
// cycle from the counter's arithmetic rules, and pins key traces to literal values.
module tb_tff_bank_sequencer;

    localparam int W   = 4;
    localparam int MOD = 10;

    localparam logic [1:0] OP_LOAD   = 2'b00;
    localparam logic [1:0] OP_UP     = 2'b01;
    localparam logic [1:0] OP_DOWN   = 2'b10;
    localparam logic [1:0] OP_PRESET = 2'b11;

    logic         clk;
    logic         reset;
    logic         cmd_valid;
    logic         cmd_ready;
    logic [1:0]   cmd_op;
    logic [W-1:0] cmd_data;
    logic [W-1:0] q_vec;
    logic [W-1:0] t_vec;
    logic [W-1:0] set_vec;
    logic         busy;
    logic         done;
    logic         err;

    typedef struct packed {
        logic [W-1:0] t;
        logic [W-1:0] set;
        logic         busy;
        logic         done;
        logic         ready;
        logic [W-1:0] q;
        logic         err;
    } exp_t;

    exp_t         exp_q[$];
    logic [W-1:0] t_log[$];
    logic [W-1:0] q_log[$];
    logic         done_log[$];
    logic [W-1:0] m_q;
    logic         m_err;
    logic         mon_en;
    int           n_checks;
    int           n_errors;

    tff_bank_sequencer #(.W(W), .MOD(MOD)) dut (
        .clk       (clk),
        .reset     (reset),
        .cmd_valid (cmd_valid),
        .cmd_ready (cmd_ready),
        .cmd_op    (cmd_op),
        .cmd_data  (cmd_data),
        .q_vec     (q_vec),
        .t_vec     (t_vec),
        .set_vec   (set_vec),
        .busy      (busy),
        .done      (done),
        .err       (err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // External toggle flip-flop bank sharing clk and reset.
    always @(posedge clk or negedge reset) begin
        if (!reset) begin
            q_vec <= '0;
        end else begin
            for (int i = 0; i < W; i++) begin
                if (set_vec[i])    q_vec[i] <= 1'b1;
                else if (t_vec[i]) q_vec[i] <= ~q_vec[i];
            end
        end
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s at %0t: got %0h, expected %0h", name, $time, act, exp);
        end
    endtask

    function automatic exp_t mk(input logic [W-1:0] t, input logic [W-1:0] s, input logic bz,
                                input logic dn, input logic [W-1:0] q, input logic e);
        exp_t r;
        r.t = t; r.set = s; r.busy = bz; r.done = dn; r.ready = ~bz; r.q = q; r.err = e;
        return r;
    endfunction

    function automatic int up_next(input int q);
        return (q >= MOD - 1) ? 0 : q + 1;
    endfunction

    function automatic int dn_next(input int q);
        return (q == 0) ? MOD - 1 : q - 1;
    endfunction

    // One compare per cycle: scheduled busy cycles first, otherwise the idle expectation.
    always @(negedge clk) begin
        exp_t e;
        bit   from_q;
        if (mon_en) begin
            from_q = (exp_q.size() > 0);
            if (from_q) e = exp_q.pop_front();
            else        e = mk('0, '0, 1'b0, 1'b0, m_q, m_err);
            check("t_vec",     32'(t_vec),     32'(e.t));
            check("set_vec",   32'(set_vec),   32'(e.set));
            check("busy",      32'(busy),      32'(e.busy));
            check("done",      32'(done),      32'(e.done));
            check("cmd_ready", 32'(cmd_ready), 32'(e.ready));
            check("q_vec",     32'(q_vec),     32'(e.q));
            check("err",       32'(err),       32'(e.err));
            if (from_q) begin
                t_log.push_back(t_vec);
                q_log.push_back(q_vec);
                done_log.push_back(done);
            end
        end
    end

    // Called at posedge+1 of an idle cycle; returns at posedge+1 of cycle 2.
    task automatic issue(input logic [1:0] op, input int data);
        int q;
        int nx;
        q         = int'(m_q);
        cmd_valid = 1'b1;
        cmd_op    = op;
        cmd_data  = W'(data);
        @(posedge clk);
        #1;
        t_log.delete();
        q_log.delete();
        done_log.delete();
        case (op)
            OP_LOAD: begin
                if (data < MOD) begin
                    exp_q.push_back(mk(W'(q ^ data), '0, 1'b1, 1'b0, W'(q), 1'b0));
                    exp_q.push_back(mk('0, '0, 1'b1, 1'b1, W'(data), 1'b0));
                    m_q   = W'(data);
                    m_err = 1'b0;
                end else begin
                    exp_q.push_back(mk('0, '0, 1'b1, 1'b1, W'(q), m_err));
                    m_err = 1'b1;
                end
            end
            OP_UP, OP_DOWN: begin
                for (int k = 0; k < data; k++) begin
                    nx = (op == OP_UP) ? up_next(q) : dn_next(q);
                    exp_q.push_back(mk(W'(q ^ nx), '0, 1'b1, 1'b0, W'(q), 1'b0));
                    q = nx;
                end
                exp_q.push_back(mk('0, '0, 1'b1, 1'b1, W'(q), 1'b0));
                m_q   = W'(q);
                m_err = 1'b0;
            end
            default: begin
                exp_q.push_back(mk('0, '1, 1'b1, 1'b0, W'(q), 1'b0));
                exp_q.push_back(mk('0, '0, 1'b1, 1'b1, W'((1 << W) - 1), 1'b0));
                m_q   = W'((1 << W) - 1);
                m_err = 1'b0;
            end
        endcase
        // Keep a conflicting command valid while busy; it must be ignored.
        cmd_op   = OP_PRESET;
        cmd_data = '1;
        @(posedge clk);
        #1;
        cmd_valid = 1'b0;
    endtask

    task automatic wait_idle();
        for (int i = 0; i < 64 && exp_q.size() != 0; i++) @(posedge clk);
        check("idle_timeout", 32'(exp_q.size()), 32'd0);
        exp_q.delete();
        #1;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1);
    end

    initial begin
        n_checks  = 0;
        n_errors  = 0;
        mon_en    = 1'b0;
        m_q       = '0;
        m_err     = 1'b0;
        cmd_valid = 1'b0;
        cmd_op    = OP_LOAD;
        cmd_data  = '0;
        reset     = 1'b1;
        #1 reset  = 1'b0;
        #2;
        check("rst_ready",  32'(cmd_ready), 32'd1);
        check("rst_busy",   32'(busy),      32'd0);
        check("rst_done",   32'(done),      32'd0);
        check("rst_err",    32'(err),       32'd0);
        check("rst_t",      32'(t_vec),     32'd0);
        check("rst_q",      32'(q_vec),     32'd0);
        @(posedge clk);
        #2 reset = 1'b1;
        mon_en = 1'b1;
        @(posedge clk);
        #1;

        issue(OP_LOAD, 7);
        wait_idle();
        check("load7_t_cycle1", 32'(t_log[0]), 32'h7);
        check("load7_q_cycle2", 32'(q_log[1]), 32'd7);
        check("load7_done_c2",  32'(done_log[1]), 32'd1);
        check("load7_ready_c3", 32'(cmd_ready), 32'd1);

        issue(OP_LOAD, 8);
        wait_idle();
        issue(OP_UP, 3);
        wait_idle();
        check("up3_len",   32'(q_log.size()), 32'd4);
        check("up3_q_c1",  32'(q_log[0]), 32'd8);
        check("up3_q_c2",  32'(q_log[1]), 32'd9);
        check("up3_q_c3",  32'(q_log[2]), 32'd0);
        check("up3_q_c4",  32'(q_log[3]), 32'd1);
        check("up3_done4", 32'(done_log[3]), 32'd1);
        check("up3_err",   32'(err), 32'd0);

        issue(OP_LOAD, 1);
        wait_idle();
        issue(OP_DOWN, 3);
        wait_idle();
        check("dn3_q_c1", 32'(q_log[0]), 32'd1);
        check("dn3_q_c2", 32'(q_log[1]), 32'd0);
        check("dn3_q_c3", 32'(q_log[2]), 32'd9);
        check("dn3_q_c4", 32'(q_log[3]), 32'd8);
        check("dn3_t_c2", 32'(t_log[1]), 32'h9);

        issue(OP_LOAD, 12);
        wait_idle();
        check("bad_load_t",   32'(t_log[0]), 32'd0);
        check("bad_load_q",   32'(q_vec), 32'd8);
        check("bad_load_err", 32'(err), 32'd1);

        issue(OP_UP, 0);
        wait_idle();
        check("up0_len",  32'(done_log.size()), 32'd1);
        check("up0_done", 32'(done_log[0]), 32'd1);
        check("up0_err",  32'(err), 32'd0);

        issue(OP_PRESET, 0);
        wait_idle();
        check("preset_q",   32'(q_vec), 32'd15);
        check("preset_err", 32'(err), 32'd0);
        issue(OP_UP, 1);
        wait_idle();
        check("preset_up1_q", 32'(q_vec), 32'd0);
        check("preset_up1_t", 32'(t_log[0]), 32'hf);

        // Reset pulsed in cycle 3 of UP 5.
        issue(OP_UP, 5);
        @(posedge clk);
        check("pre_rst_q_c2", 32'(q_log[1]), 32'd1);
        #2;
        reset = 1'b0;
        exp_q.delete();
        m_q   = '0;
        m_err = 1'b0;
        #1;
        check("mid_rst_t",     32'(t_vec),     32'd0);
        check("mid_rst_set",   32'(set_vec),   32'd0);
        check("mid_rst_busy",  32'(busy),      32'd0);
        check("mid_rst_done",  32'(done),      32'd0);
        check("mid_rst_ready", 32'(cmd_ready), 32'd1);
        check("mid_rst_q",     32'(q_vec),     32'd0);
        @(posedge clk);
        #2 reset = 1'b1;
        @(posedge clk);
        #1;
        check("post_rst_ready", 32'(cmd_ready), 32'd1);
        issue(OP_LOAD, 4);
        wait_idle();
        check("post_rst_load4_q",   32'(q_vec), 32'd4);
        check("post_rst_load4_err", 32'(err), 32'd0);

        repeat (3) @(posedge clk);
        #1;
        mon_en = 1'b0;
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
